// File: rtl/speed_ramp_if.sv
// rtl/speed_ramp_if.sv - target/step handshake channel into speed_ramp
interface speed_ramp_if #(
  parameter int NBITS = 32
);
  logic [NBITS-1:0] tgtL_i;
  logic [NBITS-1:0] tgtR_i;
  logic [NBITS-1:0] step_i;
  logic             tgt_valid_i;
  logic             tgt_ready_o;

  modport master (output tgtL_i, tgtR_i, step_i, tgt_valid_i, input tgt_ready_o);
  modport slave  (input tgtL_i, tgtR_i, step_i, tgt_valid_i, output tgt_ready_o);
endinterface

// File: rtl/speed_ramp.sv
// rtl/speed_ramp.sv - slew-limited left/right speed setpoint generator with emergency stop
// Define SPEED_RAMP_CLAMP_EN to clamp accepted targets to [-VMAX, +VMAX] and report it on sat_o.
module speed_ramp #(
  parameter int          CLK_FREQ  = 50_000_000,
  parameter int          RAMP_FREQ = 1_000,
  parameter int          NBITS     = 32,
  parameter int          STOP_STEP = 64,
  parameter logic [31:0] VMAX      = 32'h0000_7FFF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  speed_ramp_if.slave      tgt_if,
  input  logic             stop_i,
  output logic [NBITS-1:0] speedL_o,
  output logic [NBITS-1:0] speedR_o,
  output logic             done_o,
  output logic             tick_o,
  output logic             sat_o
);
  localparam int               TICK_MAX    = CLK_FREQ / RAMP_FREQ;
  localparam int               CW          = (TICK_MAX > 0) ? $clog2(TICK_MAX + 1) : 1;
  localparam logic [CW-1:0]    TICK_LAST   = CW'(TICK_MAX);
  localparam logic [NBITS-1:0] STOP_STEP_V = NBITS'(STOP_STEP);

  typedef enum logic [1:0] {IDLE, RAMP, STOP} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             tick_q, tick_d, ready_q, ready_d, done_q, done_d, sat_q, sat_d;
  logic [NBITS-1:0] spdL_q, spdL_d, spdR_q, spdR_d;
  logic [NBITS-1:0] tgtL_q, tgtL_d, tgtR_q, tgtR_d, step_q, step_d;
  logic [NBITS:0]   inL, inR;
  logic             xfer, at_tgt;

  // Difference is taken in NBITS+1 bits so full-scale opposite-sign pairs cannot wrap.
  function automatic logic [NBITS-1:0] slew(input logic [NBITS-1:0] s, t, stp);
    logic [NBITS:0] diff;
    logic [NBITS:0] mag;
    diff = {t[NBITS-1], t} - {s[NBITS-1], s};
    mag  = diff[NBITS] ? -diff : diff;
    if (mag <= {1'b0, stp}) slew = t;
    else if (diff[NBITS])   slew = s - stp;
    else                    slew = s + stp;
  endfunction

`ifdef SPEED_RAMP_CLAMP_EN
  localparam logic signed [NBITS-1:0] VMAX_P = NBITS'(VMAX);
  localparam logic signed [NBITS-1:0] VMAX_N = -VMAX_P;

  // Result is {clamped, value}.
  function automatic logic [NBITS:0] clamp(input logic [NBITS-1:0] v);
    if ($signed(v) > VMAX_P)      clamp = {1'b1, VMAX_P};
    else if ($signed(v) < VMAX_N) clamp = {1'b1, VMAX_N};
    else                          clamp = {1'b0, v};
  endfunction

  assign inL = clamp(tgt_if.tgtL_i);
  assign inR = clamp(tgt_if.tgtR_i);
`else
  logic unused_vmax;
  assign unused_vmax = ^VMAX;
  assign inL = {1'b0, tgt_if.tgtL_i};
  assign inR = {1'b0, tgt_if.tgtR_i};
`endif

  assign xfer   = tgt_if.tgt_valid_i & ready_q;
  assign at_tgt = (spdL_q == tgtL_q) && (spdR_q == tgtR_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tick_d  = 1'b0;
    spdL_d  = spdL_q;
    spdR_d  = spdR_q;
    tgtL_d  = tgtL_q;
    tgtR_d  = tgtR_q;
    step_d  = step_q;
    done_d  = at_tgt;
    sat_d   = sat_q;
    if (en) begin
      tick_d = (cnt_q == TICK_LAST);
      cnt_d  = tick_d ? '0 : cnt_q + CW'(1);
    end
    if (clr) begin
      spdL_d  = '0;
      spdR_d  = '0;
      tgtL_d  = '0;
      tgtR_d  = '0;
      state_d = IDLE;
      done_d  = 1'b1;
      sat_d   = 1'b0;
    end else if (stop_i) begin
      state_d = STOP;
      tgtL_d  = '0;
      tgtR_d  = '0;
      step_d  = STOP_STEP_V;
      if (state_q == STOP && tick_q) begin
        spdL_d = slew(spdL_q, tgtL_q, step_q);
        spdR_d = slew(spdR_q, tgtR_q, step_q);
      end
    end else begin
      // A tick coinciding with a transfer still steers toward the old targets.
      if (tick_q && state_q != IDLE) begin
        spdL_d = slew(spdL_q, tgtL_q, step_q);
        spdR_d = slew(spdR_q, tgtR_q, step_q);
      end
      case (state_q)
        IDLE, RAMP: begin
          if (xfer) begin
            tgtL_d  = inL[NBITS-1:0];
            tgtR_d  = inR[NBITS-1:0];
            step_d  = tgt_if.step_i;
            sat_d   = inL[NBITS] | inR[NBITS];
            state_d = RAMP;
          end else if (state_q == RAMP && at_tgt) begin
            state_d = IDLE;
          end
        end
        default: begin
          if (spdL_q == '0 && spdR_q == '0) state_d = IDLE;
        end
      endcase
    end
    ready_d = (state_d != STOP);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tick_q  <= 1'b0;
      ready_q <= 1'b0;
      done_q  <= 1'b1;
      sat_q   <= 1'b0;
      spdL_q  <= '0;
      spdR_q  <= '0;
      tgtL_q  <= '0;
      tgtR_q  <= '0;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      sat_q   <= sat_d;
      spdL_q  <= spdL_d;
      spdR_q  <= spdR_d;
      tgtL_q  <= tgtL_d;
      tgtR_q  <= tgtR_d;
      step_q  <= step_d;
    end
  end

  assign tgt_if.tgt_ready_o = ready_q;
  assign speedL_o = spdL_q;
  assign speedR_o = spdR_q;
  assign done_o   = done_q;
  assign tick_o   = tick_q;
  assign sat_o    = sat_q;
endmodule

// File: tb/tb_speed_ramp.sv
// tb/tb_speed_ramp.sv - scoreboard bench for speed_ramp (tick period 10 clocks, 32-bit speeds)
module tb_speed_ramp;
  localparam int NB = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          clr = 1'b0;
  logic          en = 1'b0;
  logic          stop_i = 1'b0;
  logic [NB-1:0] speedL_o, speedR_o;
  logic          done_o, tick_o, sat_o;

  int            total = 0;
  int            bad = 0;
  logic [63:0]   exp_q[$];
  logic          tick_seen = 1'b0;
  longint        mL = 0, mR = 0, tL = 0, tR = 0, mst = 0;

  speed_ramp_if #(.NBITS(NB)) tif ();

  speed_ramp #(
    .CLK_FREQ(90), .RAMP_FREQ(10), .NBITS(NB), .STOP_STEP(64), .VMAX(32'd1000)
  ) dut (
    .clk(clk), .rst(rst), .clr(clr), .en(en), .tgt_if(tif), .stop_i(stop_i),
    .speedL_o(speedL_o), .speedR_o(speedR_o), .done_o(done_o), .tick_o(tick_o), .sat_o(sat_o)
  );

  always #5 clk = ~clk;

  function automatic longint sx(input logic [31:0] v);
    return longint'($signed(v));
  endfunction

  function automatic longint mstep(input longint s, input longint t, input longint st);
    if (t - s > st) return s + st;
    else if (s - t > st) return s - st;
    else return t;
  endfunction

  task automatic predict(input int n);
    for (int i = 0; i < n; i++) begin
      mL = mstep(mL, tL, mst);
      mR = mstep(mR, tR, mst);
      exp_q.push_back({mL[31:0], mR[31:0]});
    end
  endtask

  // Outputs settle one clock after each tick pulse; pop the oldest prediction then.
  always @(negedge clk) begin
    if (tick_seen && exp_q.size() != 0) begin
      logic [63:0] e;
      e = exp_q.pop_front();
      total++;
      if ({speedL_o, speedR_o} !== e) begin
        bad++;
        $display("FAIL scoreboard speed: got %h/%h want %h/%h", speedL_o, speedR_o, e[63:32], e[31:0]);
      end
    end
    tick_seen = tick_o;
  end

  task automatic wait_tick(input int n);
    for (int k = 0; k < n; k++) begin
      int w;
      w = 0;
      while (tick_o !== 1'b1 && w < 40) begin @(negedge clk); w++; end
      if (tick_o !== 1'b1) begin
        total++; bad++;
        $display("FAIL tick_timeout: tick_o=%b after 40 clocks, need 1", tick_o);
      end
      @(negedge clk);
    end
  endtask

  task automatic send(input logic [31:0] l, input logic [31:0] r, input logic [31:0] s);
    for (int w = 0; w < 3 && tick_o === 1'b1; w++) @(negedge clk);
    tif.tgtL_i = l; tif.tgtR_i = r; tif.step_i = s; tif.tgt_valid_i = 1'b1;
    total++;
    if (tif.tgt_ready_o !== 1'b1) begin
      bad++; $display("FAIL send_ready: got %b need 1", tif.tgt_ready_o);
    end
    @(negedge clk);
    tif.tgt_valid_i = 1'b0;
    tL = sx(l); tR = sx(r); mst = longint'({32'd0, s});
`ifdef SPEED_RAMP_CLAMP_EN
    if (tL > 1000) tL = 1000;
    if (tL < -1000) tL = -1000;
    if (tR > 1000) tR = 1000;
    if (tR < -1000) tR = -1000;
`endif
  endtask

  task automatic do_clr();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    mL = 0; mR = 0; tL = 0; tR = 0;
  endtask

  task automatic test_reset();
    int n;
    tif.tgtL_i = '0; tif.tgtR_i = '0; tif.step_i = '0; tif.tgt_valid_i = 1'b0;
    rst = 1'b0; en = 1'b1;
    repeat (3) @(negedge clk);
    total += 5;
    if (tif.tgt_ready_o !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b need 0", tif.tgt_ready_o); end
    if ({speedL_o, speedR_o} !== 64'd0) begin bad++; $display("FAIL reset_speed: got %h/%h need 0/0", speedL_o, speedR_o); end
    if (done_o !== 1'b1) begin bad++; $display("FAIL reset_done: got %b need 1", done_o); end
    if (tick_o !== 1'b0) begin bad++; $display("FAIL reset_tick: got %b need 0", tick_o); end
    if (sat_o !== 1'b0) begin bad++; $display("FAIL reset_sat: got %b need 0", sat_o); end
    rst = 1'b1;
    n = 0;
    while (n < 40) begin
      @(negedge clk); n++;
      if (n == 1) begin
        total++;
        if (tif.tgt_ready_o !== 1'b1) begin bad++; $display("FAIL release_ready: got %b need 1", tif.tgt_ready_o); end
      end
      if (tick_o === 1'b1) break;
    end
    total++;
    if (n != 10) begin bad++; $display("FAIL first_tick: got %0d clocks need 10", n); end
  endtask

  task automatic test_ramp();
    // Transfer lands on the same edge as the pending tick: that tick must use the old (zero) targets.
    tif.tgtL_i = 32'd35; tif.tgtR_i = -32'sd35; tif.step_i = 32'd10; tif.tgt_valid_i = 1'b1;
    exp_q.push_back(64'd0);
    @(negedge clk);
    tif.tgt_valid_i = 1'b0;
    tL = 35; tR = -35; mst = 10;
    predict(4);
    wait_tick(4);
    total += 2;
    if (done_o !== 1'b0) begin bad++; $display("FAIL ramp_done_early: got %b need 0", done_o); end
    @(negedge clk);
    if (done_o !== 1'b1) begin bad++; $display("FAIL ramp_done_rise: got %b need 1", done_o); end
  endtask

  task automatic test_retarget();
    do_clr();
    send(32'd100, 32'd0, 32'd10);
    predict(2);
    wait_tick(2);
    send(32'd0, 32'd0, 32'd10);
    predict(3);
    wait_tick(3);
  endtask

  task automatic test_extremes();
    send(32'h7FFF_FFF0, 32'h7FFF_FFF0, 32'h7FFF_FFFF);
    predict(1);
    wait_tick(1);
    send(32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFFF);
    predict(2);
    wait_tick(2);
  endtask

  task automatic test_stop();
    do_clr();
    send(32'd500, -32'sd300, 32'd1000);
    predict(1);
    wait_tick(1);
    stop_i = 1'b1;
    tif.tgtL_i = 32'd999; tif.tgtR_i = 32'd999; tif.step_i = 32'd1; tif.tgt_valid_i = 1'b1;
    tL = 0; tR = 0; mst = 64;
    predict(8);
    @(negedge clk);
    total++;
    if (tif.tgt_ready_o !== 1'b0) begin bad++; $display("FAIL stop_ready: got %b need 0", tif.tgt_ready_o); end
    wait_tick(8);
    total++;
    if (tif.tgt_ready_o !== 1'b0) begin bad++; $display("FAIL stop_hold: got %b need 0", tif.tgt_ready_o); end
    stop_i = 1'b0;
    tif.tgt_valid_i = 1'b0;
    @(negedge clk);
    total += 3;
    if (tif.tgt_ready_o !== 1'b1) begin bad++; $display("FAIL stop_exit_ready: got %b need 1", tif.tgt_ready_o); end
    if (done_o !== 1'b1) begin bad++; $display("FAIL stop_exit_done: got %b need 1", done_o); end
    if ({speedL_o, speedR_o} !== 64'd0) begin bad++; $display("FAIL stop_exit_speed: got %h/%h need 0/0", speedL_o, speedR_o); end
  endtask

  task automatic test_enable();
    logic hold_ok;
    int   n;
    send(32'd200, -32'sd200, 32'd10);
    predict(1);
    wait_tick(1);
    repeat (3) @(negedge clk);
    en = 1'b0;
    hold_ok = 1'b1;
    repeat (50) begin
      @(negedge clk);
      if (tick_o !== 1'b0 || speedL_o !== 32'd10 || speedR_o !== -32'sd10) hold_ok = 1'b0;
    end
    total++;
    if (hold_ok !== 1'b1) begin bad++; $display("FAIL en_hold: got hold_ok=%b need 1 (last %h/%h)", hold_ok, speedL_o, speedR_o); end
    en = 1'b1;
    n = 0;
    while (n < 40) begin
      @(negedge clk); n++;
      if (tick_o === 1'b1) break;
    end
    total++;
    if (n != 6) begin bad++; $display("FAIL en_resume: got %0d clocks need 6", n); end
    predict(1);
    @(negedge clk);
    do_clr();
    total += 3;
    if ({speedL_o, speedR_o} !== 64'd0) begin bad++; $display("FAIL clr_speed: got %h/%h need 0/0", speedL_o, speedR_o); end
    if (done_o !== 1'b1) begin bad++; $display("FAIL clr_done: got %b need 1", done_o); end
    if (sat_o !== 1'b0) begin bad++; $display("FAIL clr_sat: got %b need 0", sat_o); end
  endtask

  task automatic test_clamp();
    logic es;
`ifdef SPEED_RAMP_CLAMP_EN
    es = 1'b1;
`else
    es = 1'b0;
`endif
    send(32'd5000, -32'sd200, 32'h7FFF_FFFF);
    total++;
    if (sat_o !== es) begin bad++; $display("FAIL clamp_sat_set: got %b need %b", sat_o, es); end
    predict(1);
    wait_tick(1);
    send(32'd200, 32'd0, 32'h7FFF_FFFF);
    total++;
    if (sat_o !== 1'b0) begin bad++; $display("FAIL clamp_sat_clear: got %b need 0", sat_o); end
    predict(1);
    wait_tick(1);
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_retarget();
    test_extremes();
    test_stop();
    test_enable();
    test_clamp();
    repeat (2) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL scoreboard_drain: got %0d left need 0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
